// File: rtl/inst_fetch_axi_master_pkg.sv
// Shared bus widths, AXI response codes and FSM encoding for the instruction fetch master.
package inst_fetch_axi_master_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_DATA_BUS = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } fetch_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/inst_fetch_axi_master.sv
// AXI4-Lite read initiator for instruction fetch, at most one transaction outstanding.
// Optional IFETCH_ERR_EN: report misaligned fetches and non-OKAY responses on fetch_err.
module inst_fetch_axi_master
  import inst_fetch_axi_master_pkg::*;
#(
  parameter int unsigned       ADDR_W     = INST_ADDR_BUS,
  parameter int unsigned       DATA_W     = INST_DATA_BUS,
  parameter logic [2:0]        ARPROT_VAL = 3'b100,
  parameter logic [DATA_W-1:0] RESET_INST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_err,
  output logic              stall_req,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              discard_q, discard_d;
  logic              abandon;
  logic              misaligned;
  logic              resp_err;

  // Once the IF stage flushes or withdraws its request, the bus transfer is drained silently.
  assign abandon = discard_q | flush | ~fetch_req;

`ifdef IFETCH_ERR_EN
  assign misaligned = fetch_addr[1:0] != 2'b00;
  assign resp_err   = resp_is_err(m_rresp);
`else
  logic unused_inputs;
  assign misaligned    = 1'b0;
  assign resp_err      = 1'b0;
  assign unused_inputs = ^{fetch_addr[1:0], m_rresp};
`endif

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    inst_d    = inst_q;
    discard_d = discard_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (fetch_req && !flush) begin
          if (misaligned) begin
            inst_d  = RESET_INST;
            valid_d = 1'b1;
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            araddr_d  = {fetch_addr[ADDR_W-1:2], 2'b00};
            arvalid_d = 1'b1;
            state_d   = StAddr;
          end
        end
      end
      StAddr: begin
        discard_d = abandon;
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StData;
        end
      end
      StData: begin
        discard_d = abandon;
        if (m_rvalid) begin
          rready_d = 1'b0;
          if (abandon) begin
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            inst_d  = m_rdata;
            valid_d = 1'b1;
            err_d   = resp_err;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        discard_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      inst_q    <= RESET_INST;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      discard_q <= discard_d;
    end
  end

  assign m_araddr  = araddr_q;
  assign m_arprot  = ARPROT_VAL;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  // valid_q marks the DONE cycle; a flush arriving in that cycle still kills the pulse.
  assign fetch_valid = valid_q & ~flush;
  assign fetch_err   = err_q & ~flush;
  assign fetch_inst  = inst_q;
  assign stall_req   = rst_n & fetch_req & ~fetch_valid;

endmodule

// File: tb/tb_inst_fetch_axi_master.sv
// Self-checking bench for inst_fetch_axi_master with a behavioural AXI-Lite slave.
module tb_inst_fetch_axi_master;

`ifdef IFETCH_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam logic [31:0] ResetInst = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_err;
  logic        stall_req;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  inst_fetch_axi_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .fetch_err  (fetch_err),
    .stall_req  (stall_req),
    .m_araddr   (m_araddr),
    .m_arprot   (m_arprot),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_inst;

  // Slave configuration and activity counters
  int          ar_wait = 0;
  int          r_wait  = 0;
  logic [1:0]  slave_resp = 2'b00;
  int          ar_fires = 0;
  int          r_fires  = 0;
  logic [31:0] ar_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2408_0001 + (a - 32'h10) * 32'h0101_0101;
  endfunction

  initial begin : axi_slave
    logic        ar_fire, r_fire, r_pending;
    logic [31:0] ar_a, pend_addr;
    int          ar_cnt, r_cnt;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    r_pending = 1'b0; pend_addr = '0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      ar_fire = m_arvalid & m_arready;
      r_fire  = m_rvalid & m_rready;
      ar_a    = m_araddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_arready = 1'b0; m_rvalid = 1'b0; r_pending = 1'b0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (r_fire) begin
          m_rvalid = 1'b0; r_pending = 1'b0; r_fires++;
        end
        if (ar_fire) begin
          ar_log.push_back(ar_a); ar_fires++; r_pending = 1'b1; r_cnt = 0; pend_addr = ar_a;
        end
        if (m_arvalid) begin
          if (ar_cnt >= ar_wait) m_arready = 1'b1;
          else begin m_arready = 1'b0; ar_cnt++; end
        end else begin
          m_arready = 1'b0; ar_cnt = 0;
        end
        if (r_pending && !m_rvalid) begin
          if (r_cnt >= r_wait) begin
            m_rvalid = 1'b1; m_rdata = mem_word(pend_addr); m_rresp = slave_resp;
          end else r_cnt++;
        end
      end
    end
  end

  typedef struct {
    bit          valid_seen;
    int          valid_cycle;
    int          ar_cycle;
    logic [31:0] ar_addr;
    logic [31:0] inst;
    logic        err;
    int          n_ar;
    int          stall_bad;
    int          proto_bad;
    bit          timeout;
  } fetch_res_t;

  // Drives one IF request (held until fetch_valid, dropped together with a flush) and observes it.
  task automatic run_fetch(input logic [31:0] addr, input int flush_at, input bit scramble,
                           output fetch_res_t r);
    int a0, r0, c;
    bit flushed;
    r.valid_seen = 0; r.valid_cycle = -1; r.ar_cycle = -1; r.ar_addr = '0; r.inst = '0;
    r.err = 0; r.n_ar = 0; r.stall_bad = 0; r.proto_bad = 0; r.timeout = 0;
    a0 = ar_fires; r0 = r_fires; flushed = 0; c = 0;
    @(posedge clk);
    #1;
    fetch_req = 1'b1; fetch_addr = addr; flush = 1'b0;
    forever begin
      @(negedge clk);
      if (m_arvalid) begin
        if (r.ar_cycle < 0) begin r.ar_cycle = c; r.ar_addr = m_araddr; end
        else if (m_araddr !== r.ar_addr) r.proto_bad++;
        if (m_arprot !== 3'b100) r.proto_bad++;
      end else if (r.ar_cycle >= 0 && ar_fires == a0) r.proto_bad++;
      if (fetch_err && !fetch_valid) r.proto_bad++;
      if (stall_req !== (fetch_req & ~fetch_valid)) r.stall_bad++;
      if (fetch_valid === 1'b1) begin
        r.valid_seen = 1; r.valid_cycle = c; r.inst = fetch_inst; r.err = fetch_err;
      end
      if (r.valid_seen || (flushed && r_fires != r0)) break;
      if (c >= 60) begin r.timeout = 1; break; end
      @(posedge clk);
      #1;
      c++;
      flush = (c == flush_at);
      if (flush) begin fetch_req = 1'b0; flushed = 1; end
      if (scramble) fetch_addr = $urandom;
    end
    if (!r.valid_seen) r.inst = fetch_inst;
    r.n_ar = ar_fires - a0;
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    fetch_req = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h10; flush = 1'b0;
    @(posedge clk);
    #2;
    n_checks++; if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", m_arvalid); end
    n_checks++; if (m_rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", m_rready); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    n_checks++; if (fetch_inst !== ResetInst) begin n_fail++; $display("FAIL rst_inst: got %h want %h", fetch_inst, ResetInst); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_req); end
    n_checks++; if (m_arprot !== 3'b100) begin n_fail++; $display("FAIL rst_arprot: got %b want 100", m_arprot); end
    fetch_req = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    last_inst = ResetInst;
    idle(2);
  endtask

  task automatic test_zero_wait();
    fetch_res_t r;
    ar_wait = 0; r_wait = 0; slave_resp = 2'b00;
    run_fetch(32'h0000_0010, -1, 0, r);
    n_checks++; if (r.ar_cycle !== 1) begin n_fail++; $display("FAIL t1_ar_cycle: got %0d want 1", r.ar_cycle); end
    n_checks++; if (r.ar_addr !== 32'h10) begin n_fail++; $display("FAIL t1_araddr: got %h want 00000010", r.ar_addr); end
    n_checks++; if (r.valid_cycle !== 3) begin n_fail++; $display("FAIL t1_latency: got %0d want 3", r.valid_cycle); end
    n_checks++; if (r.inst !== 32'h2408_0001) begin n_fail++; $display("FAIL t1_inst: got %h want 24080001", r.inst); end
    n_checks++; if (r.err !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b want 0", r.err); end
    n_checks++; if (r.stall_bad + r.proto_bad != 0) begin n_fail++; $display("FAIL t1_protocol: got %0d/%0d want 0/0", r.stall_bad, r.proto_bad); end
    last_inst = 32'h2408_0001;
    idle(1);
  endtask

  task automatic test_wait_states();
    fetch_res_t r;
    ar_wait = 3; r_wait = 2;
    run_fetch(32'h0000_0020, -1, 1, r);
    n_checks++; if (r.valid_cycle !== 8) begin n_fail++; $display("FAIL t2_latency: got %0d want 8", r.valid_cycle); end
    n_checks++; if (r.ar_addr !== 32'h20) begin n_fail++; $display("FAIL t2_araddr: got %h want 00000020", r.ar_addr); end
    n_checks++; if (r.inst !== mem_word(32'h20)) begin n_fail++; $display("FAIL t2_inst: got %h want %h", r.inst, mem_word(32'h20)); end
    n_checks++; if (r.proto_bad != 0) begin n_fail++; $display("FAIL t2_ar_stable: got %0d violations want 0", r.proto_bad); end
    n_checks++; if (r.stall_bad != 0) begin n_fail++; $display("FAIL t2_stall: got %0d bad cycles want 0", r.stall_bad); end
    n_checks++; if (r.n_ar != 1) begin n_fail++; $display("FAIL t2_ar_count: got %0d want 1", r.n_ar); end
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    @(negedge clk);
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL t2_single_pulse: got %b want 0", fetch_valid); end
    last_inst = mem_word(32'h20);
    idle(1);
  endtask

  task automatic test_flush();
    fetch_res_t r;
    int a0;
    ar_wait = 2; r_wait = 1;
    run_fetch(32'h0000_0030, 2, 0, r);
    n_checks++; if (r.valid_seen || r.timeout) begin n_fail++; $display("FAIL t3_addr_flush_valid: got valid=%0b timeout=%0b want 0/0", r.valid_seen, r.timeout); end
    n_checks++; if (r.n_ar != 1) begin n_fail++; $display("FAIL t3_addr_flush_ar: got %0d want 1", r.n_ar); end
    n_checks++; if (r.inst !== last_inst) begin n_fail++; $display("FAIL t3_addr_flush_inst: got %h want %h", r.inst, last_inst); end
    n_checks++; if (r.proto_bad != 0) begin n_fail++; $display("FAIL t3_arvalid_held: got %0d violations want 0", r.proto_bad); end
    ar_wait = 0; r_wait = 0;
    run_fetch(32'h0000_0034, -1, 0, r);
    n_checks++; if (r.valid_cycle !== 3 || r.inst !== mem_word(32'h34)) begin n_fail++; $display("FAIL t3_refetch: got cycle %0d inst %h want 3 %h", r.valid_cycle, r.inst, mem_word(32'h34)); end
    last_inst = mem_word(32'h34);
    r_wait = 3;
    run_fetch(32'h0000_0038, 4, 0, r);
    n_checks++; if (r.valid_seen || r.inst !== last_inst) begin n_fail++; $display("FAIL t3_data_flush: got valid=%0b inst %h want 0 %h", r.valid_seen, r.inst, last_inst); end
    a0 = ar_fires;
    @(posedge clk);
    #1;
    fetch_req = 1'b1; fetch_addr = 32'h50; flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m_arvalid !== 1'b0 || ar_fires != a0) begin n_fail++; $display("FAIL t3_idle_flush: got arvalid %b ars %0d want 0 0", m_arvalid, ar_fires - a0); end
    r_wait = 0;
    run_fetch(32'h0000_003C, 3, 0, r);
    n_checks++; if (r.valid_seen) begin n_fail++; $display("FAIL t3_done_flush: got valid=1 want 0"); end
    run_fetch(32'h0000_0044, -1, 0, r);
    n_checks++; if (r.inst !== mem_word(32'h44)) begin n_fail++; $display("FAIL t3_after: got %h want %h", r.inst, mem_word(32'h44)); end
    last_inst = mem_word(32'h44);
    idle(1);
  endtask

  task automatic test_reset_mid();
    fetch_res_t r;
    bit in_data;
    ar_wait = 0; r_wait = 6; in_data = 0;
    @(posedge clk);
    #1;
    fetch_req = 1'b1; fetch_addr = 32'h40; flush = 1'b0;
    for (int i = 0; i < 20 && !in_data; i++) begin
      @(negedge clk);
      in_data = m_rready;
    end
    n_checks++; if (!in_data) begin n_fail++; $display("FAIL t4_reach_data: got rready 0 want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({m_arvalid, m_rready, fetch_valid, fetch_err, stall_req} !== 5'b0) begin n_fail++; $display("FAIL t4_async_outputs: got %b want 00000", {m_arvalid, m_rready, fetch_valid, fetch_err, stall_req}); end
    n_checks++; if (fetch_inst !== ResetInst) begin n_fail++; $display("FAIL t4_async_inst: got %h want %h", fetch_inst, ResetInst); end
    last_inst = ResetInst;
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    r_wait = 0;
    run_fetch(32'h0000_0004, -1, 0, r);
    n_checks++; if (r.valid_cycle !== 3 || r.inst !== mem_word(32'h4) || r.n_ar != 1) begin n_fail++; $display("FAIL t4_after_reset: got cycle %0d inst %h ars %0d want 3 %h 1", r.valid_cycle, r.inst, r.n_ar, mem_word(32'h4)); end
    last_inst = mem_word(32'h4);
    idle(1);
  endtask

  task automatic test_back_to_back();
    fetch_res_t r;
    logic [31:0] exp_addr;
    ar_wait = 0; r_wait = 0; slave_resp = 2'b00;
    ar_log.delete();
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'(i * 4);
      run_fetch(exp_addr, -1, 0, r);
      n_checks++; if (r.valid_cycle !== 3 || r.ar_cycle !== 1) begin n_fail++; $display("FAIL t5_timing_%0d: got ar %0d valid %0d want 1 3", i, r.ar_cycle, r.valid_cycle); end
      n_checks++; if (r.inst !== mem_word(exp_addr)) begin n_fail++; $display("FAIL t5_inst_%0d: got %h want %h", i, r.inst, mem_word(exp_addr)); end
    end
    n_checks++; if (ar_log.size() != 3) begin n_fail++; $display("FAIL t5_ar_count: got %0d want 3", ar_log.size()); end
    for (int i = 0; i < ar_log.size() && i < 3; i++) begin
      n_checks++; if (ar_log[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL t5_ar_order_%0d: got %h want %h", i, ar_log[i], 32'(i * 4)); end
    end
    last_inst = mem_word(32'h8);
    idle(1);
  endtask

  task automatic test_err();
    fetch_res_t r;
    logic [31:0] exp_inst;
    ar_wait = 0; r_wait = 0; slave_resp = 2'b00;
    run_fetch(32'h0000_0006, -1, 0, r);
    exp_inst = ErrEn ? ResetInst : mem_word(32'h4);
    n_checks++; if (r.n_ar != (ErrEn ? 0 : 1)) begin n_fail++; $display("FAIL t6_misalign_ar: got %0d want %0d", r.n_ar, ErrEn ? 0 : 1); end
    n_checks++; if (r.valid_cycle !== (ErrEn ? 1 : 3)) begin n_fail++; $display("FAIL t6_misalign_cycle: got %0d want %0d", r.valid_cycle, ErrEn ? 1 : 3); end
    n_checks++; if (r.err !== ErrEn) begin n_fail++; $display("FAIL t6_misalign_err: got %b want %b", r.err, ErrEn); end
    n_checks++; if (r.inst !== exp_inst) begin n_fail++; $display("FAIL t6_misalign_inst: got %h want %h", r.inst, exp_inst); end
    slave_resp = 2'b10;
    run_fetch(32'h0000_0008, -1, 0, r);
    n_checks++; if (r.err !== ErrEn || r.valid_cycle !== 3) begin n_fail++; $display("FAIL t6_slverr: got err %b cycle %0d want %b 3", r.err, r.valid_cycle, ErrEn); end
    n_checks++; if (r.inst !== mem_word(32'h8)) begin n_fail++; $display("FAIL t6_slverr_inst: got %h want %h", r.inst, mem_word(32'h8)); end
    slave_resp = 2'b00;
    run_fetch(32'h0000_000C, -1, 0, r);
    n_checks++; if (r.err !== 1'b0 || r.proto_bad != 0) begin n_fail++; $display("FAIL t6_okay_err: got err %b viol %0d want 0 0", r.err, r.proto_bad); end
    last_inst = mem_word(32'hC);
    idle(1);
  endtask

  task automatic test_random();
    fetch_res_t r;
    logic [31:0] addr, exp_inst;
    int aw, rw, fa, exp_cycle, exp_ar;
    bit err_path, do_flush, exp_valid, exp_err;
    logic [1:0] resp;
    for (int i = 0; i < 24; i++) begin
      aw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      err_path = ErrEn && (addr[1:0] != 2'b00);
      do_flush = !err_path && ($urandom_range(0, 3) == 0);
      fa = do_flush ? $urandom_range(1, 2 + aw + rw) : -1;
      ar_wait = aw; r_wait = rw; slave_resp = resp;
      run_fetch(addr, fa, 1, r);
      // Transaction-level expectation from the fetch rules
      if (err_path) begin
        exp_valid = 1; exp_cycle = 1; exp_ar = 0; exp_inst = ResetInst; exp_err = 1;
      end else if (do_flush) begin
        exp_valid = 0; exp_cycle = -1; exp_ar = 1; exp_inst = last_inst; exp_err = 0;
      end else begin
        exp_valid = 1; exp_cycle = 3 + aw + rw; exp_ar = 1;
        exp_inst = mem_word({addr[31:2], 2'b00}); exp_err = ErrEn && (resp != 2'b00);
      end
      n_checks++; if (r.valid_seen != exp_valid || r.timeout) begin n_fail++; $display("FAIL rnd%0d_valid: got %0b timeout %0b want %0b", i, r.valid_seen, r.timeout, exp_valid); end
      n_checks++; if (r.valid_cycle != exp_cycle) begin n_fail++; $display("FAIL rnd%0d_cycle: got %0d want %0d", i, r.valid_cycle, exp_cycle); end
      n_checks++; if (r.n_ar != exp_ar) begin n_fail++; $display("FAIL rnd%0d_ar: got %0d want %0d", i, r.n_ar, exp_ar); end
      n_checks++; if (r.inst !== exp_inst) begin n_fail++; $display("FAIL rnd%0d_inst: got %h want %h", i, r.inst, exp_inst); end
      n_checks++; if (r.err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", i, r.err, exp_err); end
      if (exp_ar == 1) begin
        n_checks++; if (r.ar_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd%0d_araddr: got %h want %h", i, r.ar_addr, {addr[31:2], 2'b00}); end
      end
      n_checks++; if (r.stall_bad + r.proto_bad != 0) begin n_fail++; $display("FAIL rnd%0d_protocol: got %0d/%0d want 0/0", i, r.stall_bad, r.proto_bad); end
      last_inst = exp_inst;
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
    end
    idle(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
